// File: rtl/tmds_pkg.sv
// tmds_pkg: shared definitions for the TMDS receive channel.
//   - The four 10-bit control tokens that are sent during blanking (TOK_00..TOK_11).
//     Each token is named after the {c1,c0} value it carries.
//   - The alignment FSM state type and its encodings.
package tmds_pkg;

  // Control tokens, written MSB..LSB. Bit 0 is the first bit on the serial line.
  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  // Alignment FSM state encodings, kept as fixed constants so the codes stay stable.
  typedef logic [1:0] state_t;
  localparam state_t SEARCH = 2'd0;
  localparam state_t VERIFY = 2'd1;
  localparam state_t LOCKED = 2'd2;

endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational decode of one aligned 10-bit TMDS symbol.
// The transmitter-side bench also uses this module as its reference model.
//   window   in  10  aligned symbol (bit 0 = first serial bit)
//   is_token out  1  window is one of the four control tokens
//   ctrl     out  2  {c1,c0} carried by the token (0 when not a token)
//   data     out  8  video byte decoded from the window (meaningful when not a token)
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] window,
  output logic       is_token,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] t;

  always_comb begin
    is_token = 1'b1;
    ctrl     = '0;
    case (window)
      TOK_00:  ctrl = 2'b00;
      TOK_01:  ctrl = 2'b01;
      TOK_10:  ctrl = 2'b10;
      TOK_11:  ctrl = 2'b11;
      default: is_token = 1'b0;
    endcase
  end

  // Bit 9 marks an inverted payload. Bit 8 selects the XOR or the XNOR chain.
  always_comb begin
    t       = window[9] ? ~window[7:0] : window[7:0];
    data    = '0;
    data[0] = t[0];
    for (int unsigned i = 1; i < 8; i++) begin
      data[i] = window[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS receive channel. It finds word alignment and decodes one channel.
// The block tries each of the ten bit offsets in turn until it sees TOKEN_RUN
// consecutive control tokens at one offset. It then decodes continuously.
// A watchdog drops lock when no token has been seen for SEARCH_TIMEOUT cycles.
//   TOKEN_RUN       consecutive tokens required to declare lock
//   SEARCH_TIMEOUT  cycles without a token before the offset slips or lock drops
//   pixclk    in   1  pixel clock, rising edge
//   reset     in   1  asynchronous, active-high
//   tmds_in   in  10  deserialized symbol with unknown alignment (bit 0 first)
//   data_out  out  8  decoded pixel byte
//   ctrl_out  out  2  decoded {c1,c0} during blanking
//   de_out    out  1  data_out carries valid video
//   locked    out  1  alignment achieved
//   offset    out  4  current bit-slip offset, 0..9
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 2048
) (
  input  logic       pixclk,
  input  logic       reset,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int TW = $clog2(SEARCH_TIMEOUT);
  localparam int RW = $clog2(TOKEN_RUN + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [RW-1:0] RUN_LAST   = RW'(TOKEN_RUN - 1);

  state_t         state, state_n;
  logic [9:0]     prev;
  logic [3:0]     offset_n, offset_slip;
  logic [TW-1:0]  timer, timer_n;
  logic [RW-1:0]  run, run_n;
  logic [19:0]    pair, shifted;
  logic [9:0]     window;
  logic           is_token;
  logic [1:0]     dec_ctrl;
  logic [7:0]     dec_data;

  // The window may straddle the previous and current symbols. Offset 0 is prev unchanged.
  assign pair    = {tmds_in, prev};
  assign shifted = pair >> offset;
  assign window  = shifted[9:0];

  assign offset_slip = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

  tmds_symbol_decode u_decode (
    .window   (window),
    .is_token (is_token),
    .ctrl     (dec_ctrl),
    .data     (dec_data)
  );

  // One counter serves as the search timer outside LOCKED and as the watchdog inside it.
  // Leaving VERIFY on a broken run keeps the timer value, so the time spent at this offset still counts.
  always_comb begin
    state_n  = state;
    offset_n = offset;
    timer_n  = timer;
    run_n    = run;
    case (state)
      SEARCH: begin
        if (is_token) begin
          if (TOKEN_RUN <= 1) begin
            state_n = LOCKED;
            timer_n = '0;
          end else begin
            state_n = VERIFY;
            run_n   = RW'(1);
          end
        end else if (timer == TIMER_LAST) begin
          offset_n = offset_slip;
          timer_n  = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      VERIFY: begin
        if (is_token) begin
          run_n = run + RW'(1);
          if (run == RUN_LAST) begin
            state_n = LOCKED;
            timer_n = '0;
          end
        end else begin
          state_n = SEARCH;
        end
      end
      LOCKED: begin
        // A token wins over a watchdog expiry that falls in the same cycle.
        if (is_token) begin
          timer_n = '0;
        end else if (timer == TIMER_LAST) begin
          state_n  = SEARCH;
          offset_n = offset_slip;
          timer_n  = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  // Outputs follow the next state. The token that completes the run is therefore
  // already output as a control value, and outputs clear on the same edge that lock drops.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state    <= SEARCH;
      prev     <= '0;
      offset   <= '0;
      timer    <= '0;
      run      <= '0;
      locked   <= 1'b0;
      de_out   <= 1'b0;
      ctrl_out <= '0;
      data_out <= '0;
    end else begin
      state  <= state_n;
      prev   <= tmds_in;
      offset <= offset_n;
      timer  <= timer_n;
      run    <= run_n;
      locked <= (state_n == LOCKED);
      if (state_n == LOCKED) begin
        if (is_token) begin
          de_out   <= 1'b0;
          ctrl_out <= dec_ctrl;
          data_out <= '0;
        end else begin
          de_out   <= 1'b1;
          data_out <= dec_data;
        end
      end else begin
        de_out   <= 1'b0;
        ctrl_out <= '0;
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder (TOKEN_RUN=8, SEARCH_TIMEOUT=16).
// Each expected output word {locked,de,ctrl,data,offset} is queued when its symbol is driven.
// The word is popped and compared on the edge where that symbol reaches the outputs.
module tb_tmds_channel_decoder;
  import tmds_pkg::*;

  localparam int RUN = 8;
  localparam int TO  = 16;
  localparam int LOCK_EDGE = 3 * TO + RUN;

  logic       pixclk = 1'b0;
  logic       reset  = 1'b1;
  logic [9:0] tmds_in = '0;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       locked;
  logic [3:0] offset;

  always #5 pixclk = ~pixclk;

  tmds_channel_decoder #(.TOKEN_RUN(RUN), .SEARCH_TIMEOUT(TO)) dut (
    .pixclk   (pixclk),
    .reset    (reset),
    .tmds_in  (tmds_in),
    .data_out (data_out),
    .ctrl_out (ctrl_out),
    .de_out   (de_out),
    .locked   (locked),
    .offset   (offset)
  );

  typedef struct packed {
    logic [31:0] due;
    logic [15:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  string       phase    = "reset";
  logic [9:0]  last_w   = TOK_00;
  logic [9:0]  toks[4]  = '{TOK_00, TOK_01, TOK_10, TOK_11};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, want);
  endtask

  function automatic logic [15:0] pack(input logic lk, input logic de, input logic [1:0] c,
                                       input logic [7:0] d, input logic [3:0] o);
    return {lk, de, c, d, o};
  endfunction

  function automatic logic [15:0] observed();
    return {locked, de_out, ctrl_out, data_out, offset};
  endfunction

  function automatic logic [7:0] ref_data(input logic [9:0] q);
    logic [7:0] t, x, d;
    t = q[9] ? ~q[7:0] : q[7:0];
    x = t ^ {t[6:0], 1'b0};
    d = q[8] ? x : ~x;
    d[0] = t[0];
    return d;
  endfunction

  function automatic logic [1:0] ref_ctrl(input logic [9:0] w);
    case (w)
      TOK_01:  return 2'b01;
      TOK_10:  return 2'b10;
      TOK_11:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_tok(input logic [9:0] q);
    return (q == TOK_00) || (q == TOK_01) || (q == TOK_10) || (q == TOK_11);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] q;
    do q = 10'($urandom); while (is_tok(q));
    return q;
  endfunction

  // Drive one symbol, wait for the edge, then check every expectation due at this edge.
  task automatic tick(input logic [9:0] sym);
    exp_t e;
    tmds_in = sym;
    @(posedge pixclk);
    #1;
    cyc++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check(phase, 32'(observed()), 32'(e.val));
    end
  endtask

  // A symbol driven now is captured at the next edge and is decoded on the edge after that.
  task automatic send(input logic [9:0] sym, input logic [15:0] v);
    exp_t e;
    e.due = 32'(cyc + 2);
    e.val = v;
    sb_q.push_back(e);
    tick(sym);
  endtask

  // Serial stream delayed by 3 bits: each received word carries 7 bits of w and 3 bits of the previous word.
  task automatic send_rot(input logic [9:0] w, input logic [15:0] v, input logic push);
    logic [9:0] r;
    r = {w[6:0], last_w[9:7]};
    last_w = w;
    if (push) send(r, v);
    else tick(r);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(10'h0);
    tick(10'h0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] q;
    logic [9:0] w;
    int         e;

    // Reset held with random symbols on the input.
    repeat (4) tick(10'($urandom));
    check("rst_data",   32'(data_out), 32'd0);
    check("rst_ctrl",   32'(ctrl_out), 32'd0);
    check("rst_de",     32'(de_out),   32'd0);
    check("rst_locked", 32'(locked),   32'd0);
    check("rst_offset", 32'(offset),   32'd0);
    reset = 1'b0;

    phase = "aligned_lock";
    for (int i = 1; i <= RUN; i++) send(TOK_00, pack(i == RUN, 1'b0, 2'b00, 8'h00, 4'd0));

    phase = "decode";
    send(10'b0100000000, pack(1'b1, 1'b1, 2'b00, 8'h00, 4'd0));
    send(10'b1011111111, pack(1'b1, 1'b1, 2'b00, 8'hFE, 4'd0));
    send(TOK_10, pack(1'b1, 1'b0, 2'b10, 8'h00, 4'd0));
    repeat (3) begin
      q = rand_data();
      send(q, pack(1'b1, 1'b1, 2'b10, ref_data(q), 4'd0));
    end
    send(TOK_01, pack(1'b1, 1'b0, 2'b01, 8'h00, 4'd0));
    send(TOK_11, pack(1'b1, 1'b0, 2'b11, 8'h00, 4'd0));

    phase = "wdog_token_saves";
    repeat (TO - 1) begin
      q = rand_data();
      send(q, pack(1'b1, 1'b1, 2'b11, ref_data(q), 4'd0));
    end
    send(TOK_11, pack(1'b1, 1'b0, 2'b11, 8'h00, 4'd0));

    phase = "wdog_expire";
    for (int i = 1; i <= TO; i++) begin
      q = rand_data();
      if (i < TO) send(q, pack(1'b1, 1'b1, 2'b11, ref_data(q), 4'd0));
      else        send(q, pack(1'b0, 1'b0, 2'b00, 8'h00, 4'd1));
    end
    tick(10'h0);
    tick(10'h0);

    pulse_reset();
    phase = "broken_run";
    repeat (5) send(TOK_00, pack(1'b0, 1'b0, 2'b00, 8'h00, 4'd0));
    send(10'b0100000000, pack(1'b0, 1'b0, 2'b00, 8'h00, 4'd0));
    for (int i = 1; i <= RUN; i++) send(TOK_00, pack(i == RUN, 1'b0, 2'b00, 8'h00, 4'd0));
    tick(TOK_00);
    tick(TOK_00);

    pulse_reset();
    phase = "misaligned";
    last_w = TOK_00;
    for (int i = 1; i <= LOCK_EDGE + 12; i++) begin
      e = i + 1;
      w = (i - 1 <= LOCK_EDGE - 2) ? TOK_00 : toks[(i - 1) % 4];
      send_rot(w, pack(e >= LOCK_EDGE, 1'b0, (e >= LOCK_EDGE) ? ref_ctrl(w) : 2'b00, 8'h00,
                       (e >= 3 * TO) ? 4'd3 : 4'(e / TO)), 1'b1);
    end
    send_rot(TOK_11, 16'h0, 1'b0);
    send_rot(TOK_11, 16'h0, 1'b0);
    check("pre_reset_locked", 32'(locked),   32'd1);
    check("pre_reset_ctrl",   32'(ctrl_out), 32'd3);

    // Assert reset between edges. The outputs must clear without waiting for a clock.
    phase = "mid_lock_reset";
    #2;
    reset = 1'b1;
    #1;
    check("async_locked", 32'(locked),   32'd0);
    check("async_offset", 32'(offset),   32'd0);
    check("async_ctrl",   32'(ctrl_out), 32'd0);
    check("async_de",     32'(de_out),   32'd0);
    check("async_data",   32'(data_out), 32'd0);
    tick(10'h0);
    tick(10'h0);
    reset = 1'b0;
    repeat (3) tick(rand_data());
    check("resume_offset", 32'(offset), 32'd0);
    check("resume_locked", 32'(locked), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart to the HDMI TMDS transmitter: it recovers 8-bit pixel data, 2-bit control, and data-enable from one TMDS channel. The input is one 10-bit symbol per `pixclk`, already deserialized but with unknown word alignment. The block finds symbol alignment by hunting for runs of blanking-period control tokens, then decodes continuously while monitoring for lock loss. One instance per colour channel (0/1/2) sits behind the deserializer in the HDMI loopback/receive path.

## Interface
- `TOKEN_RUN`, default 8: consecutive control tokens at one offset required to declare lock.
- `SEARCH_TIMEOUT`, default 2048: `pixclk` cycles without a control token before the offset slips or lock drops. Must exceed one video line (1056 at 800x600@40 MHz).
- `pixclk` input 1: pixel clock, sole clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `tmds_in` input 10: raw symbol; bit 0 is the first serial bit.
- `data_out` output 8: decoded pixel byte.
- `ctrl_out` output 2: decoded {c1,c0} during blanking.
- `de_out` output 1: 1 when `data_out` is valid video.
- `locked` output 1: alignment achieved.
- `offset` output 4: current bit-slip offset, 0..9 (debug).

## Operation
- Window: `prev` register holds the last `tmds_in`. buf = {tmds_in, prev} is 20 bits. Window = buf[offset+9 : offset]. Offset 0 selects `prev` unchanged.
- Control tokens, MSB..LSB:
  - 1101010100 decodes to 00.
  - 0010101011 decodes to 01.
  - 0101010100 decodes to 10.
  - 1010101011 decodes to 11.
- Data decode of window q:
  - If q[9]=1, then q[7:0] is inverted first, giving t; otherwise t = q[7:0].
  - d[0] = t[0].
  - For i=1..7: d[i] = t[i]^t[i-1] when q[8]=1, else ~(t[i]^t[i-1]).
- FSM states: SEARCH, VERIFY, LOCKED. Reset state is SEARCH.
  - SEARCH, window is a token: go to VERIFY with run=1.
  - SEARCH, timer reaches SEARCH_TIMEOUT-1: offset = (offset==9) ? 0 : offset+1; timer cleared.
  - VERIFY, window is a token: run increments. When run reaches TOKEN_RUN, go to LOCKED and clear the watchdog.
  - VERIFY, window is not a token: return to SEARCH. Offset is unchanged. The timer is not cleared, so it keeps counting for this offset.
  - LOCKED: the watchdog clears on every token and increments otherwise.
  - LOCKED, watchdog reaches SEARCH_TIMEOUT-1: go to SEARCH and slip the offset as above.
  - LOCKED: if a token and watchdog expiry occur in the same cycle, the token wins.
- Outputs while LOCKED:
  - Token window: de_out=0, ctrl_out=token value, data_out=0.
  - Otherwise: de_out=1, data_out=d, ctrl_out holds its last value.
- Outputs while not LOCKED: de_out=0, data_out=0, ctrl_out=0.
- Counter widths: timer/watchdog width is $clog2(SEARCH_TIMEOUT). Run counter width is $clog2(TOKEN_RUN+1). Neither counter wraps; both saturate or clear as stated above.

## Timing
- Reset values: data_out=0, ctrl_out=0, de_out=0, locked=0, offset=0. `prev`, FSM state, and all counters also reset.
- Latency: a symbol arriving on `tmds_in` at edge N appears decoded on the outputs at edge N+2 when offset=0. For other offsets, part of the window comes from edge N+1's input; latency from the window's first bit is still 2 cycles.
- `locked` rises on the same edge that the TOKEN_RUN-th token is registered. That token is already output as a decoded control value.
- `locked` falls on the same edge the offset slips. Outputs are zero from that edge on.
- An offset change takes effect on the window at the next edge.
- Reset asserted mid-lock: all outputs go to reset values immediately (asynchronous). The block resumes in SEARCH at offset 0 after the first edge following reset deassertion.

## Structure
- `tmds_pkg` holds:
  - The four 10-bit token localparams (`TOK_00`..`TOK_11`).
  - The FSM state typedef (`SEARCH`, `VERIFY`, `LOCKED`).
- One sub-module, `tmds_symbol_decode`, purely combinational:
  - Input: 10-bit window.
  - Outputs: `is_token`, `ctrl[1:0]`, `data[7:0]`.
  - The transmitter-side bench reuses it as a reference model.

## Test plan
1. Reset check: assert `reset` for 4 cycles with `tmds_in` random. All outputs read 0, `offset`=0, `locked`=0.
2. Aligned lock: after reset, drive 8× 1101010100.
   - `locked` rises 2 cycles after the 8th symbol is presented, i.e. at edge N+2 of that symbol.
   - `ctrl_out`=00, `de_out`=0, `offset`=0.
3. Misaligned lock, TOKEN_RUN=8, SEARCH_TIMEOUT=16: feed the token stream rotated by 3 bits.
   - `offset` steps 0→1→2→3 at 16-cycle intervals.
   - Lock is reached at `offset`=3.
   - Afterwards `ctrl_out` tracks tokens 00/01/10/11 as sent.
4. Data decode while locked:
   - Symbol 0100000000 gives `data_out`=8'h00, `de_out`=1.
   - Symbol 1011111111 gives `data_out`=8'hFE.
   - The next token 0101010100 gives `de_out`=0, `ctrl_out`=10.
5. Lock loss, SEARCH_TIMEOUT=16: while locked, send only data symbols for 16 cycles.
   - `locked` falls and `offset` becomes 1.
   - A token arriving exactly on cycle 16 instead keeps `locked`=1.
6. Broken run and mid-lock reset:
   - 5 tokens followed by 1 data symbol leaves the FSM in SEARCH with `offset` unchanged.
   - Asserting `reset` while locked clears `locked` and `offset` asynchronously.
